// File: rtl/mem_crc_responder_if.sv
// Request/response bundle for mem_crc_responder: request strobe and payload in,
// one-hot state, status and read data out.
interface mem_crc_responder_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
);
    logic              e;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              inject_err;
    logic [5:0]        state;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rdata;
    logic              crc_err;

    modport master (
        output e, rw, addr, wdata, inject_err,
        input  state, busy, done, rdata, crc_err
    );

    modport slave (
        input  e, rw, addr, wdata, inject_err,
        output state, busy, done, rdata, crc_err
    );
endinterface

// File: rtl/mem_crc_responder.sv
// Small memory whose entries carry a bit-serial CRC-4 (x^4+x+1); writes compute and
// store the CRC, reads recompute it and flag a mismatch against the stored value.
module mem_crc_responder #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    mem_crc_responder_if.slave bus
);
    localparam int unsigned DEPTH   = 2 ** ADDR_W;
    localparam int unsigned CRC_W   = 4;
    localparam int unsigned ENTRY_W = DATA_W + CRC_W;
    localparam int unsigned CNT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [5:0] {
        S_IDLE  = 6'b000001,
        S_CALC  = 6'b000010,
        S_STORE = 6'b000100,
        S_FETCH = 6'b001000,
        S_CHECK = 6'b010000,
        S_DONE  = 6'b100000
    } state_t;

    state_t             st;
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  data_q;
    logic [DATA_W-1:0]  sh_q;
    logic               inj_q;
    logic [CRC_W-1:0]   crc_q;
    logic [CRC_W-1:0]   stored_crc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CRC_W-1:0]   crc_nx_c;
    logic               last_bit_c;

    // One CRC-4 step, MSB-first, non-reflected, polynomial 0x3.
    function automatic logic [CRC_W-1:0] crc4_step(input logic [CRC_W-1:0] c, input logic b);
        logic fb;
        fb = c[CRC_W-1] ^ b;
        return {c[CRC_W-2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
    endfunction

    assign crc_nx_c   = crc4_step(crc_q, sh_q[DATA_W-1]);
    assign last_bit_c = (cnt_q == CNT_W'(DATA_W - 1));

    // The visible state/busy/done lag the internal state by one register stage;
    // IDLE also requires busy low so a request overlapping the done pulse is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            st           <= S_IDLE;
            addr_q       <= '0;
            data_q       <= '0;
            sh_q         <= '0;
            inj_q        <= 1'b0;
            crc_q        <= '0;
            stored_crc_q <= '0;
            cnt_q        <= '0;
            bus.state    <= 6'b000001;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.rdata    <= '0;
            bus.crc_err  <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            bus.state <= st;
            bus.busy  <= 1'b1;
            bus.done  <= 1'b0;
            case (st)
                S_IDLE: begin
                    bus.busy <= 1'b0;
                    if (bus.e && !bus.busy) begin
                        addr_q <= bus.addr;
                        if (bus.rw) begin
                            st <= S_FETCH;
                        end else begin
                            data_q <= bus.wdata;
                            sh_q   <= bus.wdata;
                            inj_q  <= bus.inject_err;
                            crc_q  <= '0;
                            cnt_q  <= '0;
                            st     <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    crc_q <= crc_nx_c;
                    sh_q  <= sh_q << 1;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (last_bit_c) begin
                        st <= S_STORE;
                    end
                end
                S_STORE: begin
                    mem[addr_q] <= {data_q, crc_q ^ {3'b000, inj_q}};
                    bus.crc_err <= 1'b0;
                    st          <= S_DONE;
                end
                S_FETCH: begin
                    {data_q, stored_crc_q} <= mem[addr_q];
                    sh_q  <= mem[addr_q][ENTRY_W-1:CRC_W];
                    crc_q <= '0;
                    cnt_q <= '0;
                    st    <= S_CHECK;
                end
                S_CHECK: begin
                    crc_q <= crc_nx_c;
                    sh_q  <= sh_q << 1;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (last_bit_c) begin
                        bus.rdata   <= data_q;
                        bus.crc_err <= (crc_nx_c != stored_crc_q);
                        st          <= S_DONE;
                    end
                end
                S_DONE: begin
                    bus.done <= 1'b1;
                    st       <= S_IDLE;
                end
                default: begin
                    // Corrupted encoding: never expose it, fall back to IDLE.
                    bus.state <= 6'b000001;
                    bus.busy  <= 1'b0;
                    st        <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_crc_responder.sv
// Directed bench for mem_crc_responder: latency, CRC store/check, error injection,
// busy-time request dropping and reset abort.
module tb_mem_crc_responder;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    mem_crc_responder_if #(.ADDR_W(4), .DATA_W(8)) bus ();

    mem_crc_responder #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one request once the block is idle; lat is the number of edges from the
    // sampling edge until done is seen, or -1 if it never arrives.
    task automatic do_req(input logic r, input logic [3:0] a, input logic [7:0] d,
                          input logic inj, output int lat);
        int k;
        k = 0;
        while (bus.busy !== 1'b0 && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        @(negedge clk);
        bus.e = 1'b1; bus.rw = r; bus.addr = a; bus.wdata = d; bus.inject_err = inj;
        @(posedge clk); #1;
        bus.e = 1'b0; bus.inject_err = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.e = 1'b0; bus.rw = 1'b0; bus.addr = '0; bus.wdata = '0; bus.inject_err = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        n_checks++;
        if (bus.state !== 6'b000001) begin n_fail++; $display("FAIL reset_state got %b exp 000001", bus.state); end
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_busy_done got %b%b exp 00", bus.busy, bus.done); end
        n_checks++;
        if (bus.rdata !== 8'h00 || bus.crc_err !== 1'b0) begin n_fail++; $display("FAIL reset_rdata got %h/%b exp 00/0", bus.rdata, bus.crc_err); end
        @(posedge clk); #1;
        n_checks++;
        if (bus.state !== 6'b000001 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset got %b/%b exp 000001/0", bus.state, bus.busy); end
    endtask

    task automatic test_read_after_reset();
        int lat;
        do_req(1'b1, 4'hF, 8'h00, 1'b0, lat);
        n_checks++;
        if (lat !== 10) begin n_fail++; $display("FAIL read_f_latency got %0d exp 10", lat); end
        n_checks++;
        if (bus.state !== 6'b100000) begin n_fail++; $display("FAIL done_state got %b exp 100000", bus.state); end
        n_checks++;
        if (bus.rdata !== 8'h00 || bus.crc_err !== 1'b0) begin n_fail++; $display("FAIL read_f_data got %h/%b exp 00/0", bus.rdata, bus.crc_err); end
    endtask

    task automatic test_write_read();
        int lat;
        do_req(1'b0, 4'h3, 8'hA5, 1'b0, lat);
        n_checks++;
        if (lat !== 10) begin n_fail++; $display("FAIL write_latency got %0d exp 10", lat); end
        n_checks++;
        if (dut.mem[3] !== 12'hA5B) begin n_fail++; $display("FAIL stored_entry3 got %h exp a5b", dut.mem[3]); end
        do_req(1'b1, 4'h3, 8'h00, 1'b0, lat);
        n_checks++;
        if (lat !== 10) begin n_fail++; $display("FAIL read_latency got %0d exp 10", lat); end
        n_checks++;
        if (bus.rdata !== 8'hA5 || bus.crc_err !== 1'b0) begin n_fail++; $display("FAIL read3 got %h/%b exp a5/0", bus.rdata, bus.crc_err); end
    endtask

    task automatic test_inject_err();
        int lat;
        do_req(1'b0, 4'h5, 8'hFF, 1'b1, lat);
        n_checks++;
        if (dut.mem[5] !== 12'hFF5) begin n_fail++; $display("FAIL stored_entry5 got %h exp ff5", dut.mem[5]); end
        do_req(1'b1, 4'h5, 8'h00, 1'b0, lat);
        n_checks++;
        if (bus.rdata !== 8'hFF || bus.crc_err !== 1'b1) begin n_fail++; $display("FAIL read5_err got %h/%b exp ff/1", bus.rdata, bus.crc_err); end
        do_req(1'b0, 4'h6, 8'h00, 1'b0, lat);
        n_checks++;
        if (lat !== 10 || bus.crc_err !== 1'b0) begin n_fail++; $display("FAIL write_clears_err got lat %0d err %b exp 10/0", lat, bus.crc_err); end
        n_checks++;
        if (bus.rdata !== 8'hFF) begin n_fail++; $display("FAIL write_keeps_rdata got %h exp ff", bus.rdata); end
    endtask

    task automatic test_busy_ignore();
        int lat;
        int ndone;
        int first;
        ndone = 0; first = 0;
        @(posedge clk); #1;
        @(negedge clk);
        bus.e = 1'b1; bus.rw = 1'b0; bus.addr = 4'h2; bus.wdata = 8'h3C; bus.inject_err = 1'b0;
        @(posedge clk); #1;
        bus.e = 1'b0;
        for (int i = 1; i <= 24; i++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) begin
                ndone++;
                if (first == 0) first = i;
            end
            if (i == 3) begin
                bus.e = 1'b1; bus.rw = 1'b1; bus.addr = 4'h7;
            end
            if (i == 4) bus.e = 1'b0;
        end
        n_checks++;
        if (ndone !== 1 || first !== 10) begin n_fail++; $display("FAIL busy_single_done got %0d dones first %0d exp 1/10", ndone, first); end
        n_checks++;
        if (bus.state !== 6'b000001 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL busy_back_idle got %b/%b exp 000001/0", bus.state, bus.busy); end
        n_checks++;
        if (dut.mem[2] !== 12'h3C8) begin n_fail++; $display("FAIL stored_entry2 got %h exp 3c8", dut.mem[2]); end
        do_req(1'b1, 4'h7, 8'h00, 1'b0, lat);
        n_checks++;
        if (bus.rdata !== 8'h00 || bus.crc_err !== 1'b0) begin n_fail++; $display("FAIL entry7_untouched got %h/%b exp 00/0", bus.rdata, bus.crc_err); end
        do_req(1'b1, 4'h2, 8'h00, 1'b0, lat);
        n_checks++;
        if (bus.rdata !== 8'h3C || bus.crc_err !== 1'b0) begin n_fail++; $display("FAIL read2 got %h/%b exp 3c/0", bus.rdata, bus.crc_err); end
    endtask

    task automatic test_done_drop();
        int lat;
        int ndone;
        ndone = 0;
        do_req(1'b0, 4'h1, 8'h11, 1'b0, lat);
        bus.e = 1'b1; bus.rw = 1'b1; bus.addr = 4'h1;
        @(posedge clk); #1;
        bus.e = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) ndone++;
        end
        n_checks++;
        if (ndone !== 0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL done_overlap_dropped got %0d dones busy %b exp 0/0", ndone, bus.busy); end
        n_checks++;
        if (bus.rdata !== 8'h3C) begin n_fail++; $display("FAIL dropped_read_rdata got %h exp 3c", bus.rdata); end
    endtask

    task automatic test_reset_abort();
        int lat;
        int ndone;
        ndone = 0;
        @(negedge clk);
        bus.e = 1'b1; bus.rw = 1'b0; bus.addr = 4'h9; bus.wdata = 8'h5A; bus.inject_err = 1'b0;
        @(posedge clk); #1;
        bus.e = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) ndone++;
            if (i == 4) reset = 1'b1;
            if (i == 6) reset = 1'b0;
        end
        n_checks++;
        if (ndone !== 0) begin n_fail++; $display("FAIL abort_no_done got %0d exp 0", ndone); end
        n_checks++;
        if (dut.mem[9] !== 12'h000 || dut.mem[3] !== 12'h000) begin n_fail++; $display("FAIL abort_mem_clear got %h/%h exp 000/000", dut.mem[9], dut.mem[3]); end
        do_req(1'b1, 4'h9, 8'h00, 1'b0, lat);
        n_checks++;
        if (lat !== 10 || bus.rdata !== 8'h00 || bus.crc_err !== 1'b0) begin n_fail++; $display("FAIL abort_read9 got lat %0d %h/%b exp 10 00/0", lat, bus.rdata, bus.crc_err); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_read_after_reset();
        test_write_read();
        test_inject_err();
        test_busy_ignore();
        test_done_drop();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_crc_responder.md
MEM_CRC_RESPONDER -- requirements
Module: mem_crc_responder

Interface
REQ-001 Parameter ADDR_W, default 4, address width; memory depth 2**ADDR_W.
REQ-002 Parameter DATA_W, default 8, data word width; CRC field fixed at 4 bits.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 e  input  1  request strobe; sampled only in IDLE.
REQ-006 rw  input  1  request type: 1 = read, 0 = write.
REQ-007 addr  input  ADDR_W  request address.
REQ-008 wdata  input  DATA_W  write data.
REQ-009 inject_err  input  1  write request only: corrupt the stored CRC.
REQ-010 state  output  6  one-hot state: [0]IDLE [1]CALC [2]STORE [3]FETCH [4]CHECK [5]DONE.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  high exactly while in DONE (one-cycle pulse).
REQ-013 rdata  output  DATA_W  read data; registered, held until the next read completes.
REQ-014 crc_err  output  1  CRC mismatch flag of the last completed request; registered.

Function
REQ-015 Storage SHALL be 2**ADDR_W entries of {data[DATA_W-1:0], crc[3:0]}.
REQ-016 CRC SHALL be CRC-4, polynomial x^4+x+1, init 0, MSB-first, non-reflected, no final XOR, computed bit-serially at one data bit per cycle: fb = crc[3]^bit; crc = {crc[2:0],0} ^ (fb ? 4'b0011 : 4'b0000).
REQ-017 IDLE with e=1, rw=0: latch addr, wdata and inject_err; clear the CRC register and bit counter; go to CALC.
REQ-018 IDLE with e=1, rw=1: latch addr; go to FETCH.
REQ-019 IDLE with e=0: remain in IDLE.
REQ-020 CALC SHALL last exactly DATA_W cycles, consuming one bit per cycle from MSB to LSB; after the last bit, go to STORE.
REQ-021 STORE: write {data, crc ^ {3'b000, inject_err}} to mem[addr]; go to DONE.
REQ-022 FETCH: load the data register and a stored-CRC register from mem[addr]; clear the CRC register and bit counter; go to CHECK.
REQ-023 CHECK SHALL last exactly DATA_W cycles and recompute the CRC over the fetched data as in REQ-016; then go to DONE.
REQ-024 Entry into DONE from CHECK: rdata = fetched data; crc_err = (recomputed CRC != stored CRC).
REQ-025 Entry into DONE from STORE: crc_err = 0; rdata unchanged.
REQ-026 DONE SHALL go to IDLE unconditionally after one cycle.
REQ-027 Latency: with e sampled in IDLE at edge N, DONE/done SHALL be high during the cycle after edge N+10, for both reads and writes with DATA_W=8 (generally DATA_W+2).
REQ-028 e, rw, addr, wdata and inject_err SHALL be ignored while busy=1; a request coinciding with DONE is dropped and no request is queued.
REQ-029 state SHALL always be exactly one-hot; any illegal encoding SHALL recover to IDLE on the next edge.
REQ-030 Address has no wrap or bounds handling; every ADDR_W value is a valid entry.

Reset
REQ-031 reset=1 at a clock edge SHALL force: state=6'b000001, busy=0, done=0, rdata=0, crc_err=0, CRC register and bit counter=0, and every memory entry={0,4'h0}; reset has priority over all transitions.
REQ-032 Reset asserted mid-operation SHALL abort the operation; the aborted write SHALL NOT leave any entry nonzero, and no done pulse SHALL occur for it.
REQ-033 After reset, a read of any address SHALL return rdata=0, crc_err=0, because CRC(0)=0.

Verification
REQ-034 Reset -> state=000001, busy=0, done=0, rdata=00, crc_err=0.
REQ-035 Write addr 3, data A5, inject_err=0, then read addr 3 -> each done arrives 10 cycles after e; rdata=A5, crc_err=0; the stored CRC is 4'hB.
REQ-036 Write addr 5, data FF, inject_err=1, then read addr 5 -> rdata=FF, crc_err=1 (stored 4'h5 vs computed 4'h4); a following write completion clears crc_err to 0.
REQ-037 During a write to addr 2 of data 3C, pulse e with rw=1 and addr 7 at CALC cycle 4 -> exactly one done; state returns to IDLE; entry 7 is untouched.
REQ-038 Assert reset in the 5th cycle of a write of 5A to addr 9, then read addr 9 -> no done for the write; read returns rdata=00, crc_err=0.
REQ-039 Read of never-written addr F directly after reset -> rdata=00, crc_err=0, done 10 cycles after e.
